// File: rtl/tape_buffer_if.sv
// Signal bundle between the tape buffer controller, the image downloader,
// the tape loader and the external byte memory.
interface tape_buffer_if;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wait;
  logic [24:0] tape_size;
  logic [1:0]  tape_mode;
  logic        buff_rd;
  logic [24:0] buff_addr;
  logic        buff_rd_en;
  logic [7:0]  buff_din;
  logic        mem_req;
  logic        mem_we;
  logic [24:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_ack;
  logic [7:0]  mem_rdata;

  modport master (
    output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
    output buff_rd, buff_addr, mem_ack, mem_rdata,
    input  ioctl_wait, tape_size, tape_mode, buff_rd_en, buff_din,
    input  mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
    input  buff_rd, buff_addr, mem_ack, mem_rdata,
    output ioctl_wait, tape_size, tape_mode, buff_rd_en, buff_din,
    output mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/tape_buffer_ctrl.sv
// Captures a downloaded tape image into external byte memory, then serves the
// loader's single-byte random reads through a request/acknowledge memory port.
module tape_buffer_ctrl #(
  parameter logic [24:0] BASE_ADDR = 25'h1000000,
  parameter logic [24:0] MAX_SIZE  = 25'h1000000
) (
  input logic          clk_sys,
  input logic          reset,
  tape_buffer_if.slave bus
);
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_ZERO  = 2'd3
  } state_t;

  state_t      state_r;
  logic        download_prev_r;
  logic        rd_ready_r;
  logic        ioctl_wait_r;
  logic [24:0] tape_size_r;
  logic [1:0]  tape_mode_r;
  logic [7:0]  buff_din_r;
  logic        mem_req_r;
  logic        mem_we_r;
  logic [24:0] mem_addr_r;
  logic [7:0]  mem_wdata_r;

  logic        dl_rise_s;
  logic        dl_fall_s;
  logic        wr_ok_s;
  logic        rd_ok_s;
  logic        rd_hit_s;
  logic [24:0] wr_end_s;
  logic [24:0] size_base_s;
  logic [24:0] size_nxt_s;
  logic        unused_idx_s;

  function automatic logic [1:0] fmt_to_mode(input logic [1:0] code);
    logic [1:0] mode;
    case (code)
      2'b10:   mode = 2'd2;
      2'b01:   mode = 2'd1;
      default: mode = 2'd0;
    endcase
    return mode;
  endfunction

  // Download edges, acceptance of writes/reads and the next image length
  always_comb begin
    dl_rise_s   = bus.ioctl_download & ~download_prev_r;
    dl_fall_s   = ~bus.ioctl_download & download_prev_r;
    wr_ok_s     = (state_r == ST_IDLE) & bus.ioctl_wr & bus.ioctl_download
                  & (bus.ioctl_addr < MAX_SIZE);
    rd_ok_s     = (state_r == ST_IDLE) & rd_ready_r & bus.buff_rd & ~bus.ioctl_download;
    rd_hit_s    = bus.buff_addr < tape_size_r;
    wr_end_s    = bus.ioctl_addr + 25'd1;
    size_base_s = tape_size_r;
    size_nxt_s  = tape_size_r;
    if (dl_rise_s) begin
      size_base_s = 25'd0;
    end else begin
      size_base_s = tape_size_r;
    end
    if (wr_ok_s && (wr_end_s > size_base_s)) begin
      if (wr_end_s > MAX_SIZE) begin
        size_nxt_s = MAX_SIZE;
      end else begin
        size_nxt_s = wr_end_s;
      end
    end else begin
      size_nxt_s = size_base_s;
    end
  end

  // Transaction FSM with all outputs registered
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_r         <= ST_IDLE;
      download_prev_r <= 1'b0;
      rd_ready_r      <= 1'b0;
      ioctl_wait_r    <= 1'b0;
      tape_size_r     <= 25'd0;
      tape_mode_r     <= 2'd0;
      buff_din_r      <= 8'h00;
      mem_req_r       <= 1'b0;
      mem_we_r        <= 1'b0;
      mem_addr_r      <= 25'd0;
      mem_wdata_r     <= 8'h00;
    end else begin
      download_prev_r <= bus.ioctl_download;
      tape_size_r     <= size_nxt_s;
      if (dl_fall_s) begin
        tape_mode_r <= fmt_to_mode(bus.ioctl_index[7:6]);
      end
      case (state_r)
        ST_IDLE: begin
          if (wr_ok_s) begin
            state_r      <= ST_WRITE;
            mem_req_r    <= 1'b1;
            mem_we_r     <= 1'b1;
            mem_addr_r   <= BASE_ADDR + bus.ioctl_addr;
            mem_wdata_r  <= bus.ioctl_dout;
            ioctl_wait_r <= 1'b1;
            rd_ready_r   <= 1'b0;
          end else if (rd_ok_s && rd_hit_s) begin
            state_r    <= ST_READ;
            mem_req_r  <= 1'b1;
            mem_we_r   <= 1'b0;
            mem_addr_r <= BASE_ADDR + bus.buff_addr;
            rd_ready_r <= 1'b0;
          end else if (rd_ok_s) begin
            state_r    <= ST_ZERO;
            rd_ready_r <= 1'b0;
          end else begin
            rd_ready_r <= 1'b1;
          end
        end
        ST_WRITE: begin
          if (bus.mem_ack) begin
            state_r      <= ST_IDLE;
            mem_req_r    <= 1'b0;
            ioctl_wait_r <= 1'b0;
            rd_ready_r   <= 1'b1;
          end
        end
        ST_READ: begin
          if (bus.mem_ack) begin
            state_r    <= ST_IDLE;
            mem_req_r  <= 1'b0;
            buff_din_r <= bus.mem_rdata;
            rd_ready_r <= 1'b1;
          end
        end
        ST_ZERO: begin
          state_r    <= ST_IDLE;
          buff_din_r <= 8'h00;
          rd_ready_r <= 1'b1;
        end
        default: begin
          state_r      <= ST_IDLE;
          mem_req_r    <= 1'b0;
          ioctl_wait_r <= 1'b0;
          rd_ready_r   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ioctl_wait = ioctl_wait_r;
  assign bus.tape_size  = tape_size_r;
  assign bus.tape_mode  = tape_mode_r;
  assign bus.buff_din   = buff_din_r;
  assign bus.mem_req    = mem_req_r;
  assign bus.mem_we     = mem_we_r;
  assign bus.mem_addr   = mem_addr_r;
  assign bus.mem_wdata  = mem_wdata_r;
  // A download starting this very cycle must already block the loader
  assign bus.buff_rd_en = rd_ready_r & ~bus.ioctl_download;
  assign unused_idx_s   = ^bus.ioctl_index[5:0];
endmodule
